// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - packet codes and controller state encoding for usb_protocol_ctrl
package usb_pkg;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_DATA  = 3'd1,
        RX_OUT   = 3'd2,
        RX_IN    = 3'd3,
        RX_ACK   = 3'd4,
        RX_NAK   = 3'd5,
        RX_STALL = 3'd6
    } rx_pkt_t;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA  = 3'd1,
        TX_ACK   = 3'd2,
        TX_NAK   = 3'd3,
        TX_STALL = 3'd4
    } tx_pkt_t;

    // Fixed encodings kept visible for status readback compatibility.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_SEND_HS   = 3'd2;
    localparam logic [2:0] ST_SEND_DATA = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_DATA = ST_WAIT_DATA,
        S_SEND_HS   = ST_SEND_HS,
        S_SEND_DATA = ST_SEND_DATA,
        S_WAIT_ACK  = ST_WAIT_ACK
    } pctrl_state_t;

    function automatic logic is_send(input pctrl_state_t s);
        return (s == S_SEND_HS) || (s == S_SEND_DATA);
    endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// rtl/usb_timeout_timer.sv - saturating turnaround timer with one-cycle expired pulse
module usb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 800
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;
    logic         fired;

    // Count holds at TERM; fired keeps expired to a single pulse per run.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count   <= '0;
            fired   <= 1'b0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            fired   <= 1'b0;
            expired <= 1'b0;
        end else if (enable) begin
            if (count != TERM) begin
                count <= count + 1'b1;
            end
            expired <= (count == TERM) && !fired;
            if (count == TERM) begin
                fired <= 1'b1;
            end
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_protocol_ctrl.sv
// rtl/usb_protocol_ctrl.sv - USB endpoint token/handshake sequencer; USB_PCTRL_STALL_EN enables ep_halt STALL replies
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       packet_done,
    input  logic       rx_error,
    input  logic       tx_done,
    input  logic       tx_error,
    input  logic       tx_data_ready,
    input  logic       rx_data_clr,
    input  logic       ep_halt,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       d_mode,
    output logic       clear_buffer,
    output logic       rx_data_ready,
    output logic       tx_complete,
    output logic       err_pulse,
    output logic       timeout_flag
);

    pctrl_state_t state, state_n;
    logic [2:0]   pkt_sel;
    logic         clr_n, err_n, cmpl_n, tof_n, rdr_set;
    logic         halt, expired, tmr_clear;

`ifdef USB_PCTRL_STALL_EN
    assign halt = ep_halt;
`else
    logic ep_halt_unused;
    assign ep_halt_unused = ep_halt;
    assign halt           = 1'b0;
`endif

    assign tmr_clear = !((state == S_WAIT_DATA) || (state == S_WAIT_ACK));

    usb_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (tmr_clear),
        .enable  (!tmr_clear),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        pkt_sel = tx_packet;
        clr_n   = 1'b0;
        err_n   = 1'b0;
        cmpl_n  = 1'b0;
        tof_n   = timeout_flag;
        rdr_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (packet_done && rx_error) begin
                    err_n = 1'b1;
                end else if (packet_done && rx_packet == RX_OUT) begin
                    state_n = S_WAIT_DATA;
                    clr_n   = 1'b1;
                    tof_n   = 1'b0;
                end else if (packet_done && rx_packet == RX_IN) begin
                    tof_n = 1'b0;
                    if (halt) begin
                        state_n = S_SEND_HS;
                        pkt_sel = TX_STALL;
                    end else if (tx_data_ready) begin
                        state_n = S_SEND_DATA;
                        pkt_sel = TX_DATA;
                    end else begin
                        state_n = S_SEND_HS;
                        pkt_sel = TX_NAK;
                    end
                end
            end
            S_WAIT_DATA: begin
                // A packet landing on the timeout cycle is still honoured.
                if (packet_done && !rx_error && rx_packet == RX_DATA) begin
                    state_n = S_SEND_HS;
                    if (halt) begin
                        pkt_sel = TX_STALL;
                    end else if (rx_data_ready) begin
                        pkt_sel = TX_NAK;
                    end else begin
                        pkt_sel = TX_ACK;
                        rdr_set = 1'b1;
                    end
                end else if (packet_done || expired) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                    err_n   = 1'b1;
                    if (!packet_done) tof_n = 1'b1;
                end
            end
            S_SEND_HS: begin
                if (tx_error || tx_done) begin
                    state_n = S_IDLE;
                    err_n   = tx_error;
                end
            end
            S_SEND_DATA: begin
                if (tx_error) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else if (tx_done) begin
                    state_n = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (packet_done && !rx_error && rx_packet == RX_ACK) begin
                    state_n = S_IDLE;
                    cmpl_n  = 1'b1;
                    clr_n   = 1'b1;
                end else if (packet_done || expired) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    if (!packet_done) tof_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            tx_packet     <= TX_NONE;
            tx_start      <= 1'b0;
            d_mode        <= 1'b0;
            clear_buffer  <= 1'b0;
            rx_data_ready <= 1'b0;
            tx_complete   <= 1'b0;
            err_pulse     <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            state         <= state_n;
            tx_packet     <= is_send(state_n) ? pkt_sel : TX_NONE;
            tx_start      <= is_send(state_n) && !is_send(state);
            d_mode        <= is_send(state_n);
            clear_buffer  <= clr_n;
            rx_data_ready <= rdr_set | (rx_data_ready & ~rx_data_clr);
            tx_complete   <= cmpl_n;
            err_pulse     <= err_n;
            timeout_flag  <= tof_n;
        end
    end

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// tb/tb_usb_protocol_ctrl.sv - scoreboard bench for usb_protocol_ctrl
module tb_usb_protocol_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       packet_done = 1'b0, rx_error = 1'b0, tx_done = 1'b0, tx_error = 1'b0;
    logic       tx_data_ready = 1'b0, rx_data_clr = 1'b0, ep_halt = 1'b0;
    logic [2:0] tx_packet;
    logic       tx_start, d_mode, clear_buffer, rx_data_ready, tx_complete, err_pulse, timeout_flag;
    logic       probe = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int next_id = 0;

    typedef struct {
        int         id;
        int         cyc;
        logic [9:0] snap;
    } exp_t;
    exp_t sb_q[$];

    usb_protocol_ctrl #(.TIMEOUT_CYCLES(800)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_packet     (rx_packet),
        .packet_done   (packet_done),
        .rx_error      (rx_error),
        .tx_done       (tx_done),
        .tx_error      (tx_error),
        .tx_data_ready (tx_data_ready),
        .rx_data_clr   (rx_data_clr),
        .ep_halt       (ep_halt),
        .tx_packet     (tx_packet),
        .tx_start      (tx_start),
        .d_mode        (d_mode),
        .clear_buffer  (clear_buffer),
        .rx_data_ready (rx_data_ready),
        .tx_complete   (tx_complete),
        .err_pulse     (err_pulse),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // snapshot: {tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready, tx_complete, err_pulse, timeout_flag}
    function automatic logic [9:0] mk(input int st, input int pk, input int dm, input int cb,
                                      input int rdr, input int cmp, input int er, input int tof);
        logic [2:0] p;
        p = pk[2:0];
        return {st[0], p, dm[0], cb[0], rdr[0], cmp[0], er[0], tof[0]};
    endfunction

    wire [9:0] snap_now = {tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready,
                           tx_complete, err_pulse, timeout_flag};

    always @(negedge clk) begin
        if (tx_start || clear_buffer || tx_complete || err_pulse || probe) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, snap_now);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.cyc == cyc && e.snap == snap_now)
                    n_pass++;
                else
                    $display("FAIL sb_%0d cyc got=%0d want=%0d outputs got=%b want=%b",
                             e.id, cyc, e.cyc, snap_now, e.snap);
            end
        end
    end

    task automatic expect_at(input int c, input logic [9:0] s);
        exp_t e;
        e.id = next_id;
        e.cyc = c;
        e.snap = s;
        next_id++;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [2:0] p, input logic e);
        rx_packet = p;
        packet_done = 1'b1;
        rx_error = e;
        tick();
        packet_done = 1'b0;
        rx_error = 1'b0;
        rx_packet = 3'd0;
    endtask

    task automatic pulse_tx(input logic d, input logic e);
        tx_done = d;
        tx_error = e;
        tick();
        tx_done = 1'b0;
        tx_error = 1'b0;
    endtask

    task automatic clr_rdr();
        rx_data_clr = 1'b1;
        tick();
        rx_data_clr = 1'b0;
    endtask

    task automatic do_probe(input logic [9:0] s);
        expect_at(cyc, s);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) tick();
        n_rst = 1'b1;
        do_probe(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // IN with data loaded, then host ACK
        tx_data_ready = 1'b1;
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        pulse_tx(1'b1, 1'b0);
        tick();
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 1, 0, 0)); send_pkt(3'd4, 1'b0);
        repeat (2) tick();

        // IN with no data: NAK handshake held until tx_done
        tx_data_ready = 1'b0;
        c = cyc; expect_at(c + 1, mk(1, 3, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        repeat (2) tick();
        do_probe(mk(0, 3, 1, 0, 0, 0, 0, 0));
        pulse_tx(1'b1, 1'b0);
        do_probe(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // OUT then DATA: ACK, sticky rx_data_ready
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        tick();
        c = cyc; expect_at(c + 1, mk(1, 2, 1, 0, 1, 0, 0, 0)); send_pkt(3'd1, 1'b0);
        pulse_tx(1'b1, 1'b0);
        do_probe(mk(0, 0, 0, 0, 1, 0, 0, 0));

        // second OUT/DATA while still unread: NAK, no buffer clear
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 1, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        c = cyc; expect_at(c + 1, mk(1, 3, 1, 0, 1, 0, 0, 0)); send_pkt(3'd1, 1'b0);
        pulse_tx(1'b1, 1'b0);
        clr_rdr();
        do_probe(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // set and clear of rx_data_ready in the same cycle: set wins
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        rx_data_clr = 1'b1;
        c = cyc; expect_at(c + 1, mk(1, 2, 1, 0, 1, 0, 0, 0)); send_pkt(3'd1, 1'b0);
        rx_data_clr = 1'b0;
        pulse_tx(1'b1, 1'b0);
        clr_rdr();

        // OUT with no DATA: timeout exit at entry+801
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        expect_at(c + 802, mk(0, 0, 0, 1, 0, 0, 1, 1));
        while (cyc < c + 805) tick();

        // DATA arriving in exactly the timeout cycle is accepted; OUT clears timeout_flag
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        while (cyc < c + 801) tick();
        expect_at(c + 802, mk(1, 2, 1, 0, 1, 0, 0, 0)); send_pkt(3'd1, 1'b0);
        pulse_tx(1'b1, 1'b0);
        clr_rdr();

        // DATA with rx_error in WAIT_DATA
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 0, 0)); send_pkt(3'd2, 1'b0);
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 0, 1, 0)); send_pkt(3'd1, 1'b1);

        // errored token in IDLE
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 0, 0, 0, 1, 0)); send_pkt(3'd3, 1'b1);

        // IN DATA answered with NAK keeps buffer; repeat IN resends DATA
        tx_data_ready = 1'b1;
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        pulse_tx(1'b1, 1'b0);
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 0, 0, 0, 1, 0)); send_pkt(3'd5, 1'b0);
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        pulse_tx(1'b1, 1'b0);
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 1, 0, 0)); send_pkt(3'd4, 1'b0);

        // tx_done with tx_error: error wins, stray ACK afterwards ignored
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 0, 0, 0, 1, 0)); pulse_tx(1'b1, 1'b1);
        send_pkt(3'd4, 1'b0);
        tick();

        // halted endpoint
        ep_halt = 1'b1;
`ifdef USB_PCTRL_STALL_EN
        c = cyc; expect_at(c + 1, mk(1, 4, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        pulse_tx(1'b1, 1'b0);
        send_pkt(3'd4, 1'b0);
`else
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        pulse_tx(1'b1, 1'b0);
        c = cyc; expect_at(c + 1, mk(0, 0, 0, 1, 0, 1, 0, 0)); send_pkt(3'd4, 1'b0);
`endif
        ep_halt = 1'b0;
        tick();

        // reset during SEND_DATA clears outputs at once
        c = cyc; expect_at(c + 1, mk(1, 1, 1, 0, 0, 0, 0, 0)); send_pkt(3'd3, 1'b0);
        tick();
        n_rst = 1'b0;
        do_probe(mk(0, 0, 0, 0, 0, 0, 0, 0));
        n_rst = 1'b1;
        tx_data_ready = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            $display("FAIL sb_%0d never_seen want_cyc=%0d want=%b got=none", e.id, e.cyc, e.snap);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
